// File: rtl/alu.sv
// Registered integer ALU: add/sub, bitwise logic and right shifts, 1-cycle latency.
// Define ALU_STATUS_EN to add the registered zero and overflow status outputs.
module alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    input  logic [5:0]       opcode,
    output logic [WIDTH-1:0] out,
`ifdef ALU_STATUS_EN
    output logic             carry,
    output logic             zero,
    output logic             overflow
`else
    output logic             carry
`endif
);

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_SRA = 6'b000011;

    localparam logic [WIDTH-1:0] SHIFT_LIM = WIDTH'(WIDTH);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic             big_shift;
    logic [WIDTH-1:0] res_n;
    logic             carry_n;

    // Extra top bit of sum is the carry-out; of diff it is the borrow.
    assign sum       = {1'b0, num1} + {1'b0, num2};
    assign diff      = {1'b0, num1} - {1'b0, num2};
    assign big_shift = (num2 >= SHIFT_LIM);

    // Result and carry for the operation presented this cycle.
    always_comb begin
        res_n   = '0;
        carry_n = 1'b0;
        case (opcode)
            OP_ADD: begin
                res_n   = sum[WIDTH-1:0];
                carry_n = sum[WIDTH];
            end
            OP_SUB: begin
                res_n   = diff[WIDTH-1:0];
                carry_n = diff[WIDTH];
            end
            OP_AND: res_n = num1 & num2;
            OP_OR:  res_n = num1 | num2;
            OP_XOR: res_n = num1 ^ num2;
            OP_NOR: res_n = ~(num1 | num2);
            OP_SRL: res_n = big_shift ? '0 : (num1 >> num2);
            OP_SRA: begin
                if (big_shift)
                    res_n = {WIDTH{num1[WIDTH-1]}};
                else
                    res_n = WIDTH'($signed(num1) >>> num2);
            end
            default: begin
                res_n   = '0;
                carry_n = 1'b0;
            end
        endcase
    end

    // Output registers; reset clears any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            out   <= '0;
            carry <= 1'b0;
        end else begin
            out   <= res_n;
            carry <= carry_n;
        end
    end

`ifdef ALU_STATUS_EN
    logic ovf_n;

    // Signed overflow: result sign disagrees with what the operand signs imply.
    always_comb begin
        ovf_n = 1'b0;
        if (opcode == OP_ADD)
            ovf_n = (num1[WIDTH-1] == num2[WIDTH-1]) &&
                    (sum[WIDTH-1] != num1[WIDTH-1]);
        else if (opcode == OP_SUB)
            ovf_n = (num1[WIDTH-1] != num2[WIDTH-1]) &&
                    (diff[WIDTH-1] != num1[WIDTH-1]);
    end

    // Status registers track the same edge as out.
    always_ff @(posedge clk) begin
        if (reset) begin
            zero     <= 1'b1;
            overflow <= 1'b0;
        end else begin
            zero     <= (res_n == '0);
            overflow <= ovf_n;
        end
    end
`endif

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed cases plus random ops against a model.
// Status outputs are checked when ALU_STATUS_EN is defined.
module tb_alu;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] num1 = '0;
    logic [W-1:0] num2 = '0;
    logic [5:0]   opcode = '0;
    logic [W-1:0] out;
    logic         carry;
`ifdef ALU_STATUS_EN
    logic         zero;
    logic         overflow;
`endif

    int checks = 0;
    int errors = 0;

    alu #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .num1    (num1),
        .num2    (num2),
        .opcode  (opcode),
        .out     (out),
`ifdef ALU_STATUS_EN
        .carry   (carry),
        .zero    (zero),
        .overflow(overflow)
`else
        .carry   (carry)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int sgn(input int v);
        return (v >= (1 << (W - 1))) ? v - (1 << W) : v;
    endfunction

    // Reference: plain integer arithmetic on the operation definitions.
    function automatic void model(input int a, input int b, input int op,
                                  output int o, output int c,
                                  output int z, output int v);
        int m;
        int t;
        m = (1 << W);
        o = 0;
        c = 0;
        v = 0;
        case (op)
            32: begin
                t = a + b;
                o = t % m;
                c = (t >= m) ? 1 : 0;
                t = sgn(a) + sgn(b);
                v = (t > m / 2 - 1 || t < -(m / 2)) ? 1 : 0;
            end
            34: begin
                o = (a - b + m) % m;
                c = (a < b) ? 1 : 0;
                t = sgn(a) - sgn(b);
                v = (t > m / 2 - 1 || t < -(m / 2)) ? 1 : 0;
            end
            36: o = a & b;
            37: o = a | b;
            38: o = a ^ b;
            39: o = (m - 1) - (a | b);
            2: begin
                o = a;
                for (int i = 0; i < b && i < W; i++) o = o / 2;
            end
            3: begin
                o = a;
                for (int i = 0; i < b && i < W; i++)
                    o = o / 2 + ((a >= m / 2) ? m / 2 : 0);
            end
            default: o = 0;
        endcase
        z = (o == 0) ? 1 : 0;
    endfunction

    task automatic run_op(input int a, input int b, input int op,
                          input string tag);
        int eo, ec, ez, ev;
        num1   = W'(a);
        num2   = W'(b);
        opcode = 6'(op);
        model(a, b, op, eo, ec, ez, ev);
        @(posedge clk);
        #1;
        chk({tag, ".out"}, int'(out), eo);
        chk({tag, ".carry"}, int'(carry), ec);
`ifdef ALU_STATUS_EN
        chk({tag, ".zero"}, int'(zero), ez);
        chk({tag, ".ovf"}, int'(overflow), ev);
`endif
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".out"}, int'(out), 0);
        chk({tag, ".carry"}, int'(carry), 0);
`ifdef ALU_STATUS_EN
        chk({tag, ".zero"}, int'(zero), 1);
        chk({tag, ".ovf"}, int'(overflow), 0);
`endif
    endtask

    int ops[9] = '{32, 34, 36, 37, 38, 39, 2, 3, 63};

    initial begin
        int a, b, op;
        reset  = 1'b1;
        num1   = 8'h55;
        num2   = 8'hAA;
        opcode = 6'b100000;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("rst");
        reset = 1'b0;

        run_op(8'h55, 8'hAA, 32, "add_first");
        run_op(8'h01, 8'h02, 36, "and");
        run_op(8'h01, 8'h02, 37, "or");
        run_op(8'h01, 8'h02, 38, "xor");
        run_op(8'h01, 8'h02, 39, "nor");
        run_op(8'hFF, 8'h01, 32, "add_wrap");
        run_op(8'h7F, 8'h01, 32, "add_ovf");
        run_op(8'h01, 8'h02, 34, "sub_borrow");
        run_op(8'h80, 8'h01, 34, "sub_ovf");
        run_op(8'h05, 8'h05, 34, "sub_zero");
        run_op(8'h80, 3, 2, "srl3");
        run_op(8'h80, 3, 3, "sra3");
        run_op(8'h80, 9, 3, "sra9");
        run_op(8'h80, 8, 2, "srl8");
        run_op(8'h40, 8'hFF, 3, "sra_big_pos");
        run_op(8'h12, 8'h34, 63, "bad_op");
        run_op(8'h10, 8'h20, 32, "b2b_add");
        run_op(8'h10, 8'h20, 34, "b2b_sub");
        run_op(8'h10, 8'h30, 36, "b2b_and");

        num1   = 8'hFF;
        num2   = 8'h01;
        opcode = 6'b100000;
        reset  = 1'b1;
        @(posedge clk);
        #1;
        chk_reset("mid_rst");
        reset = 1'b0;

        for (int i = 0; i < 300; i++) begin
            op = ops[$urandom_range(0, 8)];
            if (op == 63) op = int'($urandom_range(0, 63));
            a = int'($urandom_range(0, 255));
            if ((op == 2 || op == 3) && $urandom_range(0, 1) == 1)
                b = int'($urandom_range(0, 12));
            else
                b = int'($urandom_range(0, 255));
            run_op(a, b, op, "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- Registered 8-bit (parameterisable) integer ALU for the datapath.
- Operations are selected by a 6-bit MIPS R-type funct-style opcode: add, subtract, bitwise logic, and logical/arithmetic right shift.
- Operands and opcode are sampled on every rising clock edge. Result and carry are presented one cycle later.

Parameters:
- WIDTH, 8, operand/result width in bits (≥2).

Ports:
- clk  input  1  system clock, rising-edge active
- reset  input  1  synchronous, active-high reset
- num1  input  WIDTH  operand A (shift source for shifts)
- num2  input  WIDTH  operand B (shift amount for shifts)
- opcode  input  6  operation select
- out  output  WIDTH  registered result
- carry  output  1  registered carry/borrow flag
- zero  output  1  registered result==0 flag (only with ALU_STATUS_EN)
- overflow  output  1  registered signed-overflow flag (only with ALU_STATUS_EN)

Behaviour:
- One clock domain; reset is synchronous and active-high.
- Reset: at a rising edge with reset=1, out=0 and carry=0; zero=1 and overflow=0 when ALU_STATUS_EN is defined. Reset overrides any operation in flight. The first valid result appears one cycle after reset deasserts.
- Latency: exactly 1 cycle. Inputs present before edge N produce outputs valid after edge N. There is no handshake; a new operation is accepted every cycle.
- Opcodes (binary):
  - 100000 ADD: {carry,out} = num1 + num2 (unsigned, WIDTH+1 bits); carry is the carry-out.
  - 100010 SUB: out = num1 − num2 modulo 2^WIDTH; carry = 1 when num1 < num2 unsigned (borrow), else 0.
  - 100100 AND: out = num1 & num2; carry = 0.
  - 100101 OR: out = num1 | num2; carry = 0.
  - 100110 XOR: out = num1 ^ num2; carry = 0.
  - 100111 NOR: out = ~(num1 | num2); carry = 0.
  - 000010 SRL: out = num1 logically shifted right by unsigned num2, zero fill. If num2 ≥ WIDTH, out = 0. carry = 0.
  - 000011 SRA: out = num1 arithmetically shifted right by unsigned num2, sign fill. If num2 ≥ WIDTH, out = all copies of num1[WIDTH−1]. carry = 0.
  - Any other opcode: out = 0, carry = 0. No error flag.
- Wrap-around: ADD and SUB wrap modulo 2^WIDTH. The carry flag is the only indication of unsigned wrap.
- Next-state logic is purely combinational from the current inputs. No state persists between operations other than the output registers.

Optional Feature:
- Macro: ALU_STATUS_EN.
- Defined:
  - Adds outputs zero and overflow, both registered with the same 1-cycle latency as out.
  - zero = 1 when the registered out equals 0, for every opcode including undefined ones.
  - overflow = two's-complement signed overflow: for ADD, operands have equal sign and the result sign differs; for SUB, operands have different sign and the result sign differs from num1. overflow = 0 for all other opcodes.
- Undefined: zero and overflow ports are absent. All other behaviour is unchanged.

Test Plan:
- Assert reset for 2 cycles with num1=0x55, num2=0xAA, opcode=ADD → out=0x00, carry=0 (zero=1). Deassert reset → out=0xFF, carry=0 after the next edge.
- num1=0x01, num2=0x02, opcode=100100 (AND) → out=0x00, carry=0 one cycle later. Same operands with OR → 0x03; XOR → 0x03; NOR → 0xFC.
- ADD 0xFF+0x01 → out=0x00, carry=1 (zero=1, overflow=0). ADD 0x7F+0x01 → out=0x80, carry=0 (overflow=1).
- SUB 0x01−0x02 → out=0xFF, carry=1. SUB 0x80−0x01 → out=0x7F, carry=0 (overflow=1). SUB 0x05−0x05 → out=0x00 (zero=1).
- SRL 0x80 by 3 → 0x10. SRA 0x80 by 3 → 0xF0. SRA 0x80 by 9 → 0xFF. SRL 0x80 by 8 → 0x00. carry=0 in all four cases.
- Back-to-back ops ADD, SUB, AND on consecutive cycles → each result appears exactly 1 cycle after its inputs. opcode 111111 → out=0x00, carry=0. Reset asserted mid-stream → outputs are 0 on that edge.
